// File: rtl/cpu_pkg.sv
// Shared core encodings: ALU opcodes, condition codes, NZCV bit positions, flag-unit states.
package cpu_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_RSB = 4'h3,
        ALU_ADD = 4'h4, ALU_ADC = 4'h5, ALU_SBC = 4'h6, ALU_RSC = 4'h7,
        ALU_TST = 4'h8, ALU_TEQ = 4'h9, ALU_CMP = 4'hA, ALU_CMN = 4'hB,
        ALU_ORR = 4'hC, ALU_MOV = 4'hD, ALU_BIC = 4'hE, ALU_MVN = 4'hF
    } alu_op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MBUSY = 1'b1
    } flag_state_e;

    // Logical ops take their carry from the shifter rather than the adder.
    function automatic logic is_logical_op(input logic [3:0] op);
        return op inside {ALU_AND, ALU_EOR, ALU_TST, ALU_TEQ,
                          ALU_ORR, ALU_MOV, ALU_BIC, ALU_MVN};
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluation against NZCV; zero latency, no flow control.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ~(n ^ v);
            COND_LT: cond_ex = n ^ v;
            COND_GT: cond_ex = ~z & ~(n ^ v);
            COND_LE: cond_ex = z | (n ^ v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Condition gating, NZCV update, banked flag save/restore and multi-cycle op tracking.
// Gated outputs are combinational; flags update on the next edge. Stall holds while a multiply runs.
module cond_flag_unit
    import cpu_pkg::*;
#(
    parameter int         NUM_BANKS    = 4,
    parameter logic [3:0] MC_FLAG_MASK = 4'b1100,
    localparam int        BANK_W       = $clog2(NUM_BANKS)
)(
    input  logic              CLK,
    input  logic              Reset,
    input  logic              InstrValid,
    input  logic [3:0]        Cond,
    input  logic [3:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              NoWrite,
    input  logic              MS,
    input  logic [3:0]        ALUOp,
    input  logic [3:0]        ALUFlags,
    input  logic              ShifterCarry,
    input  logic              MDone,
    input  logic [3:0]        MFlags,
    input  logic              SaveReq,
    input  logic              RestoreReq,
    input  logic [BANK_W-1:0] BankSel,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              MStart,
    output logic              CondEx,
    output logic              Stall,
    output logic              MBusy,
    output logic [3:0]        Flags,
    output logic              CFlag
);

    // Bank storage spans every BankSel code; slot 0 and out-of-range slots are never written.
    localparam int SLOTS = 2 ** BANK_W;

    flag_state_e state_q, state_d;
    logic [3:0]  flags_q, flags_d;
    logic [3:0]  pend_q, pend_d;
    logic [3:0]  bank_q [SLOTS];
    logic [3:0]  bank_d [SLOTS];

    logic       go;
    logic       in_idle;
    logic       m_start;
    logic       bank_ok;
    logic [3:0] wmask;

    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (CondEx)
    );

    assign in_idle = (state_q == ST_IDLE);
    assign go      = InstrValid & CondEx;
    assign m_start = in_idle & MS & go;
    assign bank_ok = (BankSel != '0) && (32'(BankSel) < 32'(NUM_BANKS));

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            flags_q <= '0;
            pend_q  <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            pend_q  <= pend_d;
            bank_q  <= bank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (m_start) state_d = ST_MBUSY;
            ST_MBUSY: if (MDone)   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        PCSrc    = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        MStart   = 1'b0;
        Stall    = 1'b0;
        MBusy    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                PCSrc    = PCS & go;
                RegWrite = RegW & go & ~NoWrite;
                MemWrite = MemW & go;
                MStart   = m_start;
            end
            ST_MBUSY: begin
                MBusy = 1'b1;
                Stall = ~MDone;
            end
            default: ;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        pend_d  = pend_q;
        bank_d  = bank_q;
        wmask   = '0;
        if (in_idle) begin
            // The multiply owns the flag write; the ALU result that cycle is discarded.
            wmask = m_start ? 4'b0000 : (FlagW & {4{go}});
            if (m_start) pend_d = FlagW & MC_FLAG_MASK;
            if (wmask[FLAG_N]) flags_d[FLAG_N] = ALUFlags[FLAG_N];
            if (wmask[FLAG_Z]) flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            if (wmask[FLAG_V]) flags_d[FLAG_V] = ALUFlags[FLAG_V];
            if (wmask[FLAG_C]) begin
                flags_d[FLAG_C] = is_logical_op(ALUOp) ? ShifterCarry : ALUFlags[FLAG_C];
            end
            // Save sees pre-update flags; restore wins over any same-cycle ALU write.
            if (SaveReq && bank_ok)    bank_d[BankSel] = flags_q;
            if (RestoreReq && bank_ok) flags_d = bank_q[BankSel];
        end else if (MDone) begin
            flags_d = (flags_q & ~pend_q) | (MFlags & pend_q);
            pend_d  = '0;
        end
    end

    assign Flags = flags_q;
    assign CFlag = flags_q[FLAG_C];

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed plus random stimulus for cond_flag_unit, compared against a behavioural flag model.
module tb_cond_flag_unit;

    localparam int         NB   = 3;
    localparam logic [3:0] MASK = 4'b1100;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       InstrValid, PCS, RegW, MemW, NoWrite, MS, ShifterCarry, MDone;
    logic       SaveReq, RestoreReq;
    logic [3:0] Cond, FlagW, ALUOp, ALUFlags, MFlags;
    logic [1:0] BankSel;
    logic       PCSrc, RegWrite, MemWrite, MStart, CondEx, Stall, MBusy, CFlag;
    logic [3:0] Flags;

    logic [3:0] m_flags;
    logic [3:0] m_pend;
    logic [3:0] m_bank [4];
    bit         m_busy;
    logic [3:0] prior;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    cond_flag_unit #(.NUM_BANKS(NB), .MC_FLAG_MASK(MASK)) dut (
        .CLK(CLK), .Reset(Reset), .InstrValid(InstrValid), .Cond(Cond), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .MS(MS), .ALUOp(ALUOp),
        .ALUFlags(ALUFlags), .ShifterCarry(ShifterCarry), .MDone(MDone), .MFlags(MFlags),
        .SaveReq(SaveReq), .RestoreReq(RestoreReq), .BankSel(BankSel), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MStart(MStart), .CondEx(CondEx),
        .Stall(Stall), .MBusy(MBusy), .Flags(Flags), .CFlag(CFlag)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Conditions come in complementary pairs: odd codes invert the even predicate.
    function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    r = z;
            3'd1:    r = cy;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = cy && !z;
            3'd5:    r = (n == v);
            3'd6:    r = !z && (n == v);
            default: r = (c == 4'hE);
        endcase
        if (c[3:1] != 3'd7 && c[0]) r = !r;
        return r;
    endfunction

    function automatic bit m_logical(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF};
    endfunction

    task automatic clear_in();
        InstrValid = 0; Cond = 4'hE; FlagW = 0; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
        MS = 0; ALUOp = 4'h4; ALUFlags = 0; ShifterCarry = 0; MDone = 0; MFlags = 0;
        SaveReq = 0; RestoreReq = 0; BankSel = 0;
    endtask

    task automatic model_reset();
        m_flags = 0; m_pend = 0; m_busy = 0;
        for (int i = 0; i < 4; i++) m_bank[i] = 0;
    endtask

    // One clock: check every output mid-cycle, advance the model, land 1ns after the edge.
    task automatic cycle();
        bit g;
        logic [3:0] nf, old_bank;
        @(negedge CLK);
        g = !m_busy && InstrValid && m_cond(Cond, m_flags);
        chk1("condex", CondEx, m_cond(Cond, m_flags));
        chk1("pcsrc", PCSrc, g && PCS);
        chk1("regwrite", RegWrite, g && RegW && !NoWrite);
        chk1("memwrite", MemWrite, g && MemW);
        chk1("mstart", MStart, g && MS);
        chk1("stall", Stall, m_busy && !MDone);
        chk1("mbusy", MBusy, m_busy);
        chk4("flags", Flags, m_flags);
        chk1("cflag", CFlag, m_flags[1]);
        nf = m_flags;
        if (m_busy) begin
            if (MDone) begin
                nf = (m_flags & ~m_pend) | (MFlags & m_pend);
                m_pend = 0;
                m_busy = 0;
            end
        end else begin
            if (g && MS) begin
                m_pend = FlagW & MASK;
                m_busy = 1;
            end else if (g) begin
                for (int i = 0; i < 4; i++)
                    if (FlagW[i]) nf[i] = (i == 1 && m_logical(ALUOp)) ? ShifterCarry : ALUFlags[i];
            end
            if (BankSel != 0 && int'(BankSel) < NB) begin
                old_bank = m_bank[BankSel];
                if (SaveReq) m_bank[BankSel] = m_flags;
                if (RestoreReq) nf = old_bank;
            end
        end
        m_flags = nf;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_in();
        model_reset();
        Reset = 1;
        @(posedge CLK);
        #1;
        chk1("rst_mbusy", MBusy, 1'b0);
        chk1("rst_stall", Stall, 1'b0);
        chk4("rst_flags", Flags, 4'b0000);
        chk1("rst_cflag", CFlag, 1'b0);
        chk1("rst_pcsrc", PCSrc, 1'b0);
        Reset = 0;
        @(posedge CLK);
        #1;

        // EQ with Z clear, then CMP sets Z, then EQ branch taken
        clear_in(); InstrValid = 1; Cond = 4'h0; PCS = 1;
        cycle();
        clear_in(); InstrValid = 1; ALUOp = 4'hA; FlagW = 4'b1111; ALUFlags = 4'b0100;
        cycle();
        chk4("cmp_flags", Flags, 4'b0100);
        clear_in(); InstrValid = 1; Cond = 4'h0; PCS = 1;
        cycle();

        // Logical op carries from shifter, arithmetic op from ALU
        clear_in(); InstrValid = 1; ALUOp = 4'hD; FlagW = 4'b0010; ShifterCarry = 1;
        cycle();
        chk1("mov_carry", CFlag, 1'b1);
        clear_in(); InstrValid = 1; ALUOp = 4'h4; FlagW = 4'b0010; ShifterCarry = 1;
        cycle();
        chk1("add_carry", CFlag, 1'b0);

        // MULS: three stalled cycles, then commit N/Z only
        prior = Flags;
        clear_in(); InstrValid = 1; MS = 1; FlagW = 4'b1111; ALUFlags = 4'b0011;
        cycle();
        for (int i = 0; i < 3; i++) begin
            clear_in();
            chk1("mul_stall", Stall, 1'b1);
            cycle();
        end
        clear_in(); MDone = 1; MFlags = 4'b1011; InstrValid = 1; PCS = 1;
        #1;
        chk1("mdone_stall", Stall, 1'b0);
        cycle();
        chk4("mul_flags", Flags, {2'b10, prior[1:0]});
        clear_in(); InstrValid = 1; PCS = 1;
        cycle();

        // Bank save / restore, with restore overriding a same-cycle ALU write
        clear_in(); InstrValid = 1; FlagW = 4'b1111; ALUFlags = 4'b1010;
        cycle();
        chk4("set_1010", Flags, 4'b1010);
        clear_in(); SaveReq = 1; BankSel = 2;
        cycle();
        clear_in(); InstrValid = 1; FlagW = 4'b1111; ALUFlags = 4'b0101;
        cycle();
        chk4("set_0101", Flags, 4'b0101);
        clear_in(); RestoreReq = 1; BankSel = 2; InstrValid = 1; FlagW = 4'b1111; ALUFlags = 4'b0101;
        cycle();
        chk4("restore_b2", Flags, 4'b1010);

        // Bank 0 and the first out-of-range bank are ignored
        clear_in(); RestoreReq = 1; BankSel = 0;
        cycle();
        chk4("restore_b0", Flags, 4'b1010);
        clear_in(); RestoreReq = 1; SaveReq = 1; BankSel = 2'(NB);
        cycle();
        chk4("restore_oob", Flags, 4'b1010);

        // Swap with bank 1 (still reset value), then restore it back
        clear_in(); SaveReq = 1; RestoreReq = 1; BankSel = 1;
        cycle();
        chk4("swap_flags", Flags, 4'b0000);
        clear_in(); RestoreReq = 1; BankSel = 1;
        cycle();
        chk4("swap_back", Flags, 4'b1010);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            clear_in();
            InstrValid   = ($urandom_range(0, 3) != 0);
            Cond         = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
            FlagW        = 4'($urandom);
            PCS          = 1'($urandom);
            RegW         = 1'($urandom);
            MemW         = 1'($urandom);
            NoWrite      = 1'($urandom);
            MS           = ($urandom_range(0, 7) == 0);
            ALUOp        = 4'($urandom);
            ALUFlags     = 4'($urandom);
            ShifterCarry = 1'($urandom);
            MDone        = ($urandom_range(0, 3) == 0);
            MFlags       = 4'($urandom);
            SaveReq      = ($urandom_range(0, 3) == 0);
            RestoreReq   = ($urandom_range(0, 3) == 0);
            BankSel      = 2'($urandom);
            cycle();
        end

        // Reset while a multiply is in flight; a late MDone must be ignored
        clear_in(); MDone = 1;
        cycle();
        clear_in(); InstrValid = 1; MS = 1; FlagW = 4'b1111;
        cycle();
        clear_in();
        cycle();
        #2;
        Reset = 1;
        #1;
        chk1("rst_mid_mbusy", MBusy, 1'b0);
        chk1("rst_mid_stall", Stall, 1'b0);
        chk4("rst_mid_flags", Flags, 4'b0000);
        model_reset();
        @(posedge CLK);
        #1;
        Reset = 0;
        clear_in(); MDone = 1; MFlags = 4'b1111;
        cycle();
        chk4("late_mdone", Flags, 4'b0000);
        chk1("late_mbusy", MBusy, 1'b0);

        // NV never passes
        clear_in(); InstrValid = 1; Cond = 4'hF; PCS = 1; RegW = 1; MemW = 1; MS = 1;
        FlagW = 4'b1111; ALUFlags = 4'b1111;
        #1;
        chk1("nv_pcsrc", PCSrc, 1'b0);
        chk1("nv_mstart", MStart, 1'b0);
        cycle();
        chk4("nv_flags", Flags, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
